// File: rtl/pu_riscv_biu_arb.sv
// Two-port arbiter sharing one BIU between the instruction (port 0) and data (port 1)
// memory controllers; ownership is held for a whole burst and across locked sequences.
module pu_riscv_biu_arb #(
  parameter int XLEN         = 64,
  parameter int PLEN         = 64,
  parameter int ARB_MODE     = 0,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           biu_req_i,
  output logic [1:0]           biu_req_ack_o,
  output logic [1:0]           biu_d_ack_o,
  input  logic [1:0][PLEN-1:0] biu_adri_i,
  output logic [1:0][PLEN-1:0] biu_adro_o,
  input  logic [1:0][2:0]      biu_size_i,
  input  logic [1:0][2:0]      biu_type_i,
  input  logic [1:0][2:0]      biu_prot_i,
  input  logic [1:0]           biu_lock_i,
  input  logic [1:0]           biu_we_i,
  input  logic [1:0][XLEN-1:0] biu_d_i,
  output logic [1:0][XLEN-1:0] biu_q_o,
  output logic [1:0]           biu_ack_o,
  output logic [1:0]           biu_err_o,
  output logic                 biu_stb_o,
  input  logic                 biu_stb_ack_i,
  input  logic                 biu_d_ack_i,
  output logic [PLEN-1:0]      biu_adri_o,
  input  logic [PLEN-1:0]      biu_adro_i,
  output logic [2:0]           biu_size_o,
  output logic [2:0]           biu_type_o,
  output logic [2:0]           biu_prot_o,
  output logic                 biu_lock_o,
  output logic                 biu_we_o,
  output logic [XLEN-1:0]      biu_d_o,
  input  logic [XLEN-1:0]      biu_q_i,
  input  logic                 biu_ack_i,
  input  logic                 biu_err_i,
  output logic [1:0]           grant_o,
  output logic                 busy_o
);

  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] WRAP16 = 3'b110;
  localparam logic [2:0] INCR16 = 3'b111;

  localparam int             ICW      = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [ICW-1:0] IDLE_MAX = ICW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

  state_t         state_q;
  logic           owner_q;
  logic           rr_last_q;
  logic           lock_flag_q;
  logic [4:0]     beat_cnt_q;
  logic [ICW-1:0] idle_cnt_q;
  logic [1:0]     grant_q;
  logic           busy_q;

  logic sel;
  logic src;
  logic fwd;
  logic accept;
  logic xfer_end;

  function automatic logic [4:0] beats(input logic [2:0] t);
    case (t)
      WRAP4,  INCR4:  beats = 5'd4;
      WRAP8,  INCR8:  beats = 5'd8;
      WRAP16, INCR16: beats = 5'd16;
      default:        beats = 5'd1;
    endcase
  endfunction

  // On a tie the port that did not win last time goes first, unless data has fixed priority
  always_comb begin
    sel = 1'b0;
    case (biu_req_i)
      2'b10:   sel = 1'b1;
      2'b11:   sel = (ARB_MODE == 1) ? 1'b1 : ~rr_last_q;
      default: sel = 1'b0;
    endcase
  end

  assign src      = (state_q == IDLE) ? sel : owner_q;
  assign fwd      = (state_q != IDLE) || (|biu_req_i);
  assign accept   = biu_stb_o & biu_stb_ack_i;
  assign xfer_end = biu_err_i || (biu_ack_i && beat_cnt_q == 5'd1);

  always_comb begin
    biu_stb_o     = 1'b0;
    biu_adri_o    = '0;
    biu_size_o    = '0;
    biu_type_o    = '0;
    biu_prot_o    = '0;
    biu_lock_o    = 1'b0;
    biu_we_o      = 1'b0;
    biu_d_o       = '0;
    biu_req_ack_o = '0;
    biu_d_ack_o   = '0;
    biu_adro_o    = '0;
    biu_q_o       = '0;
    biu_ack_o     = '0;
    biu_err_o     = '0;
    if (fwd) begin
      biu_adri_o = biu_adri_i[src];
      biu_size_o = biu_size_i[src];
      biu_type_o = biu_type_i[src];
      biu_prot_o = biu_prot_i[src];
      biu_lock_o = biu_lock_i[src];
      biu_we_o   = biu_we_i[src];
      biu_d_o    = biu_d_i[src];
    end
    case (state_q)
      IDLE, LOCKED: begin
        biu_stb_o          = biu_req_i[src];
        biu_req_ack_o[src] = biu_stb_ack_i & biu_req_i[src];
      end
      BUSY: begin
        biu_q_o[0]             = biu_q_i;
        biu_q_o[1]             = biu_q_i;
        biu_ack_o[owner_q]     = biu_ack_i;
        biu_err_o[owner_q]     = biu_err_i;
        biu_d_ack_o[owner_q]   = biu_d_ack_i;
        biu_adro_o[owner_q]    = biu_adro_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b0;
      lock_flag_q <= 1'b0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          owner_q     <= sel;
          rr_last_q   <= sel;
          lock_flag_q <= biu_lock_i[sel];
          beat_cnt_q  <= beats(biu_type_i[sel]);
          grant_q     <= 2'b01 << sel;
          busy_q      <= 1'b1;
          state_q     <= BUSY;
        end
        BUSY: begin
          if (biu_ack_i) beat_cnt_q <= beat_cnt_q - 5'd1;
          // an error aborts whatever beats remain
          if (xfer_end) begin
            idle_cnt_q <= '0;
            if (lock_flag_q) begin
              state_q <= LOCKED;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        LOCKED: begin
          if (accept) begin
            lock_flag_q <= biu_lock_i[owner_q];
            beat_cnt_q  <= beats(biu_type_i[owner_q]);
            state_q     <= BUSY;
          end else if (!biu_req_i[owner_q]) begin
            if (idle_cnt_q == IDLE_MAX) begin
              lock_flag_q <= 1'b0;
              grant_q     <= '0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + ICW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_pu_riscv_biu_arb.sv
// Randomized bench for pu_riscv_biu_arb: a transaction-level model predicts the winner and
// each forwarded beat; a monitor branch pops expected beats whenever the DUT presents a response.
module tb_pu_riscv_biu_arb;
  localparam int XLEN         = 64;
  localparam int PLEN         = 64;
  localparam int ARB_MODE     = 0;
  localparam int LOCK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]           req, lock, we;
  logic [1:0][PLEN-1:0] adri;
  logic [1:0][2:0]      size, typ, prot;
  logic [1:0][XLEN-1:0] d;
  logic                 stb_ack, dack, ack, err;
  logic [PLEN-1:0]      adro;
  logic [XLEN-1:0]      q;

  logic [1:0]           biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o, grant_o;
  logic [1:0][PLEN-1:0] biu_adro_o;
  logic [1:0][XLEN-1:0] biu_q_o;
  logic                 biu_stb_o, biu_lock_o, biu_we_o, busy_o;
  logic [PLEN-1:0]      biu_adri_o;
  logic [2:0]           biu_size_o, biu_type_o, biu_prot_o;
  logic [XLEN-1:0]      biu_d_o;

  pu_riscv_biu_arb #(.XLEN(XLEN), .PLEN(PLEN), .ARB_MODE(ARB_MODE), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .biu_req_i(req), .biu_req_ack_o(biu_req_ack_o), .biu_d_ack_o(biu_d_ack_o),
    .biu_adri_i(adri), .biu_adro_o(biu_adro_o),
    .biu_size_i(size), .biu_type_i(typ), .biu_prot_i(prot),
    .biu_lock_i(lock), .biu_we_i(we), .biu_d_i(d), .biu_q_o(biu_q_o),
    .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(stb_ack), .biu_d_ack_i(dack),
    .biu_adri_o(biu_adri_o), .biu_adro_i(adro),
    .biu_size_o(biu_size_o), .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o),
    .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_d_o(biu_d_o),
    .biu_q_i(q), .biu_ack_i(ack), .biu_err_i(err),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct {
    int              port;
    logic            ack;
    logic            err;
    logic            dack;
    logic [PLEN-1:0] a;
    logic [XLEN-1:0] q;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   last_win = 0;     // last granted port; 0 after reset so port 1 takes the first tie
  int   lock_owner = -1;  // port holding a lock, -1 when none

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beats(input logic [2:0] t);
    case (t)
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      3'b110, 3'b111: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic logic any_out();
    return |{biu_req_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o, biu_stb_o,
             biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o, biu_we_o, biu_d_o,
             grant_o, busy_o};
  endfunction

  task automatic set_port(input int p, input logic r, input logic [2:0] t, input logic l);
    req[p]  = r;
    typ[p]  = t;
    lock[p] = l;
    adri[p] = {$urandom, $urandom};
    d[p]    = {$urandom, $urandom};
    size[p] = 3'($urandom);
    prot[p] = 3'($urandom);
    we[p]   = 1'($urandom);
  endtask

  task automatic run_round(input logic r0, input logic r1, input logic [2:0] t0, input logic [2:0] t1,
                           input logic l0, input logic l1, input int err_beat);
    int         w, n, gap, waited;
    logic [1:0] oh;
    set_port(0, r0, t0, l0);
    set_port(1, r1, t1, l1);
    @(negedge clk);
    if (lock_owner >= 0) begin
      chk("locked_grant", 64'({busy_o, grant_o}), 64'({1'b1, 2'b01 << lock_owner}));
      if (!req[lock_owner]) begin
        waited = 0;
        while (!biu_stb_o && waited < 4 * LOCK_TIMEOUT) begin
          tick();
          waited++;
          @(negedge clk);
        end
        chk("lock_timeout_cycles", 64'(waited), 64'(LOCK_TIMEOUT));
        lock_owner = -1;
        chk("timeout_to_idle", 64'({busy_o, grant_o}), 64'(0));
      end
    end else begin
      chk("idle_between", 64'({busy_o, grant_o}), 64'(0));
    end

    if (lock_owner >= 0)        w = lock_owner;
    else if (req[0] && req[1])  w = (ARB_MODE == 1) ? 1 : 1 - last_win;
    else                        w = req[1] ? 1 : 0;
    oh = 2'b01 << w;

    gap = $urandom_range(0, 2);
    repeat (gap) begin
      chk("pre_ack_stb", 64'({biu_stb_o, biu_req_ack_o, biu_adri_o == adri[w]}), 64'(4'b1001));
      tick();
      @(negedge clk);
    end
    stb_ack = 1'b1;
    #1;
    chk("req_ack", 64'(biu_req_ack_o), 64'(oh));
    chk("fwd_adr", biu_adri_o, adri[w]);
    chk("fwd_ctl", 64'({biu_type_o, biu_lock_o, biu_we_o, biu_size_o, biu_prot_o}),
                   64'({typ[w], lock[w], we[w], size[w], prot[w]}));
    tick();
    stb_ack  = 1'b0;
    req[w]   = 1'b0;
    last_win = w;

    n = beats(typ[w]);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("busy_state", 64'({busy_o, grant_o, biu_stb_o, biu_req_ack_o}), 64'({1'b1, oh, 3'b000}));
        tick();
      end
      d[w] = {$urandom, $urandom};
      ack  = (k == err_beat) ? 1'($urandom) : 1'b1;
      err  = (k == err_beat);
      dack = we[w];
      adro = {$urandom, $urandom};
      q    = {$urandom, $urandom};
      expq.push_back('{w, ack, err, dack, adro, q});
      @(negedge clk);
      chk("wdata_track", biu_d_o, d[w]);
      tick();
      ack  = 1'b0;
      err  = 1'b0;
      dack = 1'b0;
      if (k == err_beat) break;
    end
    lock_owner = lock[w] ? w : -1;

    // a stray ack after an aborted burst must reach nobody
    if (err_beat >= 0 && err_beat < n && !lock[w]) begin
      ack = 1'b1;
      q   = {$urandom, $urandom};
      @(negedge clk);
      chk("post_err_idle", 64'({busy_o, grant_o}), 64'(0));
      tick();
      ack = 1'b0;
    end
  endtask

  initial begin
    req = '0; lock = '0; we = '0; adri = '0; size = '0; typ = '0; prot = '0; d = '0;
    stb_ack = 1'b0; dack = 1'b0; ack = 1'b0; err = 1'b0; adro = '0; q = '0;
    fork
      begin : monitor
        exp_t       e;
        logic [1:0] moh;
        forever begin
          @(negedge clk);
          if (rst_n && (|{biu_ack_o, biu_err_o, biu_d_ack_o})) begin
            if (expq.size() == 0) begin
              chk("unexpected_resp", 64'({biu_ack_o, biu_err_o, biu_d_ack_o}), 64'(0));
            end else begin
              e   = expq.pop_front();
              moh = 2'b01 << e.port;
              chk("resp_flags", 64'({biu_ack_o, biu_err_o, biu_d_ack_o}),
                  64'({e.ack ? moh : 2'b00, e.err ? moh : 2'b00, e.dack ? moh : 2'b00}));
              chk("resp_q_owner", biu_q_o[e.port], e.q);
              chk("resp_q_other", biu_q_o[1 - e.port], e.q);
              chk("resp_adro", biu_adro_o[e.port], e.a);
              chk("resp_adro_other", biu_adro_o[1 - e.port], 64'(0));
            end
          end
        end
      end
      begin : stim
        logic r0, r1;
        #12;
        chk("reset_outputs", 64'(any_out()), 64'(0));
        tick();
        rst_n = 1'b1;

        run_round(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        repeat (4) run_round(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        run_round(1'b1, 1'b1, 3'b101, 3'b101, 1'b0, 1'b0, -1);
        run_round(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        run_round(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, -1);
        run_round(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        run_round(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        run_round(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, -1);
        run_round(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        run_round(1'b1, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1);

        for (int i = 0; i < 60; i++) begin
          r0 = 1'($urandom);
          r1 = 1'($urandom);
          if (lock_owner == 0 && !r0) r1 = 1'b1;
          if (lock_owner == 1 && !r1) r0 = 1'b1;
          if (!r0 && !r1) r0 = 1'b1;
          run_round(r0, r1, 3'($urandom), 3'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1);
        end
        if (lock_owner >= 0)
          run_round(lock_owner == 0, lock_owner == 1, 3'b000, 3'b000, 1'b0, 1'b0, -1);

        // reset in the middle of an INCR4 burst
        set_port(0, 1'b1, 3'b011, 1'b0);
        set_port(1, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        stb_ack = 1'b1;
        tick();
        stb_ack = 1'b0;
        req[0]  = 1'b0;
        ack  = 1'b1;
        dack = we[0];
        adro = {$urandom, $urandom};
        q    = {$urandom, $urandom};
        expq.push_back('{0, 1'b1, 1'b0, we[0], adro, q});
        tick();
        q     = {$urandom, $urandom};
        rst_n = 1'b0;
        #1;
        chk("reset_mid_burst_outputs", 64'(any_out()), 64'(0));
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", 64'({busy_o, grant_o}), 64'(0));
        tick();
        ack  = 1'b0;
        dack = 1'b0;
        last_win   = 0;
        lock_owner = -1;
        run_round(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, -1);

        tick();
        chk("queue_drained", 64'(expq.size()), 64'(0));
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pu_riscv_biu_arb.md
Name: pu_riscv_biu_arb

Overview:
- Two-requester arbiter sharing one BIU port between the instruction memory controller (port 0) and the data memory controller (port 1).
- Grants one requester per bus transaction, holds the grant for the full burst, and keeps ownership across locked (atomic) sequences.
- Routes address, data, acknowledge and error signals between the owner and the BIU.
- Sits between the core memory controllers and the AHB-Lite BIU.

Parameters:
- XLEN, 64, data width.
- PLEN, 64, physical address width.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to port 1 (data).
- LOCK_TIMEOUT, 16, maximum number of idle cycles the owner may hold a lock without issuing a request.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- biu_req_i  in  [1:0]  per-port access request
- biu_req_ack_o  out  [1:0]  per-port request accepted
- biu_d_ack_o  out  [1:0]  per-port write-data acknowledge
- biu_adri_i  in  [1:0][PLEN-1:0]  per-port start address
- biu_adro_o  out  [1:0][PLEN-1:0]  per-port current transfer address
- biu_size_i, biu_type_i, biu_prot_i  in  [1:0][2:0]  per-port size, burst type, protection
- biu_lock_i, biu_we_i  in  [1:0]  per-port lock and write enable
- biu_d_i  in  [1:0][XLEN-1:0]  per-port write data
- biu_q_o  out  [1:0][XLEN-1:0]  per-port read data
- biu_ack_o, biu_err_o  out  [1:0]  per-port transfer acknowledge and error
- biu_stb_o  out  1  request to BIU
- biu_stb_ack_i  in  1  BIU request accepted
- biu_d_ack_i  in  1  BIU write-data acknowledge
- biu_adri_o  out  PLEN  address to BIU
- biu_adro_i  in  PLEN  transfer address from BIU
- biu_size_o, biu_type_o, biu_prot_o  out  3  size, burst type, protection to BIU
- biu_lock_o, biu_we_o  out  1  lock and write enable to BIU
- biu_d_o  out  XLEN  write data to BIU
- biu_q_i  in  XLEN  read data from BIU
- biu_ack_i, biu_err_i  in  1  transfer acknowledge and error from BIU
- grant_o  out  [1:0]  one-hot current owner; 0 in IDLE
- busy_o  out  1  state is not IDLE

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset state:
  - state=IDLE, owner=0, rr_last=0 (port 1 wins the first round-robin tie).
  - beat_cnt=0, lock_flag=0, idle_cnt=0.
  - With no requests, every output is 0.
- States: IDLE, BUSY, LOCKED.
- IDLE:
  - Select sel combinationally:
    - Only one port requesting: that port wins.
    - Both ports requesting, ARB_MODE=1: port 1 wins.
    - Both ports requesting, ARB_MODE=0: the port that is not rr_last wins.
  - Forward sel's adri/size/type/lock/prot/we/d to the BIU and drive biu_stb_o=biu_req_i[sel].
  - biu_req_ack_o[sel]=biu_stb_ack_i; the losing port's biu_req_ack_o is 0.
  - On biu_stb_ack_i, register:
    - owner=sel and rr_last=sel.
    - lock_flag=biu_lock_i[sel].
    - beat_cnt=beats(type).
    - Next state BUSY.
  - No acknowledge: the request is re-arbitrated next cycle; there is no sticky grant.
- beats(type), using the peripheral_biu_pkg constants:
  - SINGLE=1.
  - INCR4/WRAP4=4.
  - INCR8/WRAP8=8.
  - INCR16/WRAP16=16.
  - Any other encoding counts as 1.
  - beat_cnt is 5 bits.
- BUSY:
  - biu_stb_o=0. Downstream request fields stay muxed from the owner, so biu_d_o tracks the owner's data for write bursts.
  - biu_q_o of both ports = biu_q_i.
  - Owner only: ack, err, d_ack and adro are passed through. All other ports see 0.
  - beat_cnt decrements on biu_ack_i.
  - End of transfer is biu_ack_i with beat_cnt==1, or biu_err_i at any beat (an error aborts the remaining beats).
  - At end of transfer: lock_flag=1 goes to LOCKED with idle_cnt=0; lock_flag=0 goes to IDLE.
- LOCKED:
  - grant_o stays on owner.
  - Only the owner's request is forwarded; the other port's biu_req_ack_o=0 even if it requests.
  - Owner request accepted (biu_stb_ack_i): go to BUSY and reload beat_cnt and lock_flag from the new request.
  - Owner biu_req_i=0: idle_cnt increments. When idle_cnt reaches LOCK_TIMEOUT-1, go to IDLE and drop the lock.
- Simultaneous events:
  - biu_ack_i and biu_err_i in the same cycle: treated as an error, burst ends, err goes to the owner.
  - In IDLE, a request arriving in the same cycle as the previous transfer's final ack is not possible, because the FSM has not yet reached IDLE; it is taken in the next cycle.
- Reset asserted mid-burst: return immediately to the reset state. Outstanding BIU beats after reset are ignored because owner=0 and state=IDLE, so no ack is forwarded.

Test Plan:
- Port 0 SINGLE read at 0x1000, acked after 2 cycles, biu_q_i=0xDEAD -> biu_ack_o=2'b01, biu_q_o[0]=0xDEAD, state back to IDLE one cycle after the ack, grant_o=0.
- Both ports request in the same cycle, ARB_MODE=0, repeated 4 times -> grants alternate 1,0,1,0. With ARB_MODE=1 -> port 1 wins all 4.
- Port 0 INCR8 burst while port 1 requests mid-burst -> port 1 sees biu_req_ack_o=0 until the 8th ack, then is granted in the next IDLE cycle.
- Port 1 issues a locked SINGLE then an unlocked SINGLE while port 0 requests continuously -> port 0 is blocked until the second transfer completes, with no port 0 ack in between.
- Port 1 locked SINGLE followed by no further request, LOCK_TIMEOUT=16 -> returns to IDLE after 16 idle cycles, and port 0 is granted next.
- INCR4 burst with biu_err_i on beat 2 -> biu_err_o pulses for the owner only, FSM returns to IDLE, and no further acks are forwarded. Reset during an INCR4 burst -> all outputs 0 and grant_o=0.
